// File: rtl/bcd_pkg.sv
// Shared BCD digit type, digit ceiling and clamp helper for the countdown digit chain.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  // Non-BCD codes (A..F) saturate to 9 so a bad preset still counts down sanely.
  function automatic bcd_digit_t bcd_clamp(input bcd_digit_t v);
    return (v > BCD_MAX) ? BCD_MAX : v;
  endfunction

endpackage

// File: rtl/bcd_countdown_timer_if.sv
// Control/status bundle between the game datapath and a BCD countdown timer.
interface bcd_countdown_timer_if #(
  parameter int NDIGITS = 3
);

  logic                   load;
  logic [4*NDIGITS-1:0]   load_value;
  logic                   dec;
  logic [4*NDIGITS-1:0]   digits;
  logic                   zero;
  logic                   running;
  logic                   expired;

  modport master (
    output load, load_value, dec,
    input  digits, zero, running, expired
  );

  modport slave (
    input  load, load_value, dec,
    output digits, zero, running, expired
  );

endinterface

// File: rtl/bcd_down_digit.sv
// One BCD digit of the down-counter: loadable, decrements on borrow, wraps 0 -> 9.
module bcd_down_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  bcd_digit_t load_d,
  input  logic       borrow_in,
  output bcd_digit_t d,
  output logic       is_zero,
  output logic       borrow_out
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      d <= '0;
    end else if (load) begin
      d <= bcd_clamp(load_d);
    end else if (borrow_in) begin
      d <= (d == 4'd0) ? BCD_MAX : d - 4'd1;
    end
  end

  assign is_zero    = (d == 4'd0);
  // A digit sitting at 0 passes the borrow on to the next more significant digit.
  assign borrow_out = borrow_in & is_zero;

endmodule

// File: rtl/bcd_countdown_timer.sv
// Loadable NDIGITS-digit BCD countdown with borrow chain, zero/running status and expiry pulse.
module bcd_countdown_timer
  import bcd_pkg::*;
#(
  parameter int NDIGITS = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  bcd_countdown_timer_if.slave     bus
);

  logic [NDIGITS:0]   borrow;
  logic [NDIGITS-1:0] digit_zero;
  logic               count_zero;
  logic               upper_zero;
  logic               load_nonzero;
  logic               hit_zero;
  logic               running_p1;
  logic               expired_p1;
  logic               unused_borrow;

  // Counting is frozen at zero and whenever a load takes the cycle.
  assign borrow[0]     = bus.dec & ~bus.load & ~count_zero;
  assign unused_borrow = borrow[NDIGITS];

  for (genvar i = 0; i < NDIGITS; i++) begin : g_digit
    bcd_down_digit u_digit (
      .clk        (clk),
      .reset      (reset),
      .load       (bus.load),
      .load_d     (bus.load_value[4*i +: 4]),
      .borrow_in  (borrow[i]),
      .d          (bus.digits[4*i +: 4]),
      .is_zero    (digit_zero[i]),
      .borrow_out (borrow[i+1])
    );
  end

  assign count_zero = &digit_zero;

  always_comb begin
    upper_zero   = 1'b1;
    load_nonzero = 1'b0;
    for (int i = 1; i < NDIGITS; i++) begin
      upper_zero = upper_zero & digit_zero[i];
    end
    for (int i = 0; i < NDIGITS; i++) begin
      load_nonzero = load_nonzero | (bcd_clamp(bus.load_value[4*i +: 4]) != 4'd0);
    end
  end

  // Count is exactly 1 and this cycle's decrement is going through.
  assign hit_zero = borrow[0] & upper_zero & (bus.digits[3:0] == 4'd1);

  // ---- stage p1: registered status flags ----
  always_ff @(posedge clk) begin
    if (!reset) begin
      running_p1 <= 1'b0;
      expired_p1 <= 1'b0;
    end else begin
      expired_p1 <= hit_zero;
      if (bus.load) begin
        running_p1 <= load_nonzero;
      end else if (hit_zero) begin
        running_p1 <= 1'b0;
      end
    end
  end

  assign bus.zero    = count_zero;
  assign bus.running = running_p1;
  assign bus.expired = expired_p1;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Scoreboard bench: integer-valued countdown model queues expectations, a monitor pops and compares.
module tb_bcd_countdown_timer;

  localparam int NDIGITS = 3;
  localparam int W       = 4 * NDIGITS;

  typedef struct {
    logic [W-1:0] digits;
    bit           zero;
    bit           running;
    bit           expired;
  } exp_t;

  logic clk;
  logic reset;

  bcd_countdown_timer_if #(.NDIGITS(NDIGITS)) bus ();

  bcd_countdown_timer #(.NDIGITS(NDIGITS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Model state: the count as a plain decimal integer.
  int cnt    = 0;
  bit run_m  = 0;

  function automatic int clamp_val(input logic [W-1:0] v);
    int r;
    r = 0;
    for (int i = NDIGITS - 1; i >= 0; i--) begin
      int d;
      d = int'(v[4*i +: 4]);
      if (d > 9) d = 9;
      r = r * 10 + d;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] to_bcd(input int n);
    logic [W-1:0] r;
    int t;
    r = '0;
    t = n;
    for (int i = 0; i < NDIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic step(input bit rst_n, input bit ld, input logic [W-1:0] lv, input bit dc);
    exp_t e;
    @(negedge clk);
    reset          = rst_n;
    bus.load       = ld;
    bus.load_value = lv;
    bus.dec        = dc;
    e.expired = 1'b0;
    if (!rst_n) begin
      cnt   = 0;
      run_m = 0;
    end else if (ld) begin
      cnt   = clamp_val(lv);
      run_m = (cnt != 0);
    end else if (dc && cnt > 0) begin
      cnt = cnt - 1;
      if (cnt == 0) begin
        e.expired = 1'b1;
        run_m     = 0;
      end
    end
    e.digits  = to_bcd(cnt);
    e.zero    = (cnt == 0);
    e.running = run_m;
    expq.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, '0, 0);
  endtask

  task automatic decs(input int n);
    for (int i = 0; i < n; i++) step(1, 0, '0, 1);
  endtask

  // Monitor: one expectation per clock edge, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        checks++;
        if (bus.digits !== e.digits || bus.zero !== e.zero ||
            bus.running !== e.running || bus.expired !== e.expired) begin
          errors++;
          $display("FAIL cycle%0d: got digits=%h zero=%b running=%b expired=%b, want digits=%h zero=%b running=%b expired=%b",
                   cyc, bus.digits, bus.zero, bus.running, bus.expired,
                   e.digits, e.zero, e.running, e.expired);
        end
      end
    end
  end

  initial begin
    reset          = 1'b0;
    bus.load       = 1'b0;
    bus.load_value = '0;
    bus.dec        = 1'b0;

    // Reset state
    step(0, 0, '0, 0);
    step(0, 0, '0, 1);
    idle(1);

    // Multi-digit borrow through 100 -> 099
    step(1, 1, 12'h105, 0);
    decs(6);

    // Expiry and dec-at-zero
    step(1, 1, 12'h002, 0);
    decs(3);
    idle(1);

    // Load beats a simultaneous dec
    step(1, 1, 12'h050, 1);
    decs(1);

    // Per-digit clamp, then load zero while running
    step(1, 1, 12'h0AF, 0);
    decs(1);
    step(1, 1, 12'h000, 0);
    decs(1);

    // Reset mid-count
    step(1, 1, 12'h040, 0);
    decs(3);
    step(0, 0, '0, 1);
    idle(1);

    // Reload while running, then run out with dec held
    step(1, 1, 12'h003, 0);
    decs(1);
    step(1, 1, 12'h001, 1);
    decs(2);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      int r;
      logic [W-1:0] lv;
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 1) == 1) lv = W'($urandom_range(0, 15));
      else                           lv = W'($urandom);
      if (r < 2)       step(0, 0, lv, $urandom_range(0, 1) == 1);
      else if (r < 10) step(1, 1, lv, $urandom_range(0, 1) == 1);
      else             step(1, 0, lv, $urandom_range(0, 3) != 0);
    end

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", expq.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
